// File: rtl/id_stage_pipe_if.sv
// Handshake and decoded-slot bundle between upstream fetch, the ID stage and EX.
// master: upstream/downstream environment side; slave: the ID stage itself.
interface id_stage_pipe_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc;
  logic [31:0]     in_instr;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [14:0]     out_ridx;
  logic [XLEN-1:0] out_rs1_data;
  logic [XLEN-1:0] out_rs2_data;
  logic [XLEN-1:0] out_imm;
  logic [11:0]     out_ctrl;

  modport master (
    output in_valid, in_pc, in_instr, out_ready,
    input  in_ready, out_valid, out_pc, out_ridx,
           out_rs1_data, out_rs2_data, out_imm, out_ctrl
  );

  modport slave (
    input  in_valid, in_pc, in_instr, out_ready,
    output in_ready, out_valid, out_pc, out_ridx,
           out_rs1_data, out_rs2_data, out_imm, out_ctrl
  );
endinterface

// File: rtl/id_stage_pipe.sv
// RV32I/E instruction decode stage: register file, combinational decode and
// register read, one-entry output slot with valid/ready handshake and
// load-use hazard stall.
// Optional macro ID_WB_BYPASS_EN: a writeback and a read of the same register
// at the same edge capture the writeback data instead of the old value.
module id_stage_pipe #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            flush,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic [4:0]      ex_rd,
  input  logic            ex_mem_read,
  id_stage_pipe_if.slave  bus
);

  localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

  typedef enum logic [6:0] {
    OPC_LOAD   = 7'b0000011,
    OPC_OPIMM  = 7'b0010011,
    OPC_AUIPC  = 7'b0010111,
    OPC_STORE  = 7'b0100011,
    OPC_OP     = 7'b0110011,
    OPC_LUI    = 7'b0110111,
    OPC_BRANCH = 7'b1100011,
    OPC_JALR   = 7'b1100111,
    OPC_JAL    = 7'b1101111
  } opcode_e;

  function automatic logic idx_ok(input logic [4:0] idx);
    return int'(idx) < NREGS;
  endfunction

  logic [XLEN-1:0] regs [NREGS];

  logic [31:0]     instr;
  logic [4:0]      rs1, rs2, rd;
  logic [2:0]      funct3;
  logic            known, rs1_used, rs2_used, rd_used, illegal;
  logic [31:0]     imm32;
  logic [3:0]      alu_op;
  logic            reg_write, mem_read, mem_write, branch, jump, alu_src_imm, wb_sel_mem;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic            hazard, ready, accept;

  logic            out_valid_q;
  logic [XLEN-1:0] out_pc_q, out_rs1_q, out_rs2_q, out_imm_q;
  logic [14:0]     out_ridx_q;
  logic [11:0]     out_ctrl_q;

  assign instr  = bus.in_instr;
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];

  // Register file write port; x0 and out-of-range indices are never written.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[AW'(i)] <= '0;
    end else if (wb_we && wb_rd != 5'd0 && idx_ok(wb_rd)) begin
      regs[wb_rd[AW-1:0]] <= wb_data;
    end
  end

  // Operand read; x0 and out-of-range indices read as zero.
  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if (rs1 != 5'd0 && idx_ok(rs1)) rs1_val = regs[rs1[AW-1:0]];
    if (rs2 != 5'd0 && idx_ok(rs2)) rs2_val = regs[rs2[AW-1:0]];
`ifdef ID_WB_BYPASS_EN
    if (wb_we && wb_rd != 5'd0 && wb_rd == rs1 && idx_ok(rs1)) rs1_val = wb_data;
    if (wb_we && wb_rd != 5'd0 && wb_rd == rs2 && idx_ok(rs2)) rs2_val = wb_data;
`endif
  end

  // Opcode decode: immediate format, register usage and control bits.
  always_comb begin
    known       = 1'b1;
    rs1_used    = 1'b1;
    rs2_used    = 1'b0;
    rd_used     = 1'b0;
    imm32       = '0;
    alu_op      = '0;
    reg_write   = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    branch      = 1'b0;
    jump        = 1'b0;
    alu_src_imm = 1'b0;
    wb_sel_mem  = 1'b0;
    case (instr[6:0])
      OPC_LUI, OPC_AUIPC: begin
        rs1_used    = 1'b0;
        rd_used     = 1'b1;
        reg_write   = 1'b1;
        alu_src_imm = 1'b1;
        imm32       = {instr[31:12], 12'b0};
      end
      OPC_JAL: begin
        rs1_used  = 1'b0;
        rd_used   = 1'b1;
        reg_write = 1'b1;
        jump      = 1'b1;
        imm32     = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      OPC_JALR: begin
        rd_used     = 1'b1;
        reg_write   = 1'b1;
        jump        = 1'b1;
        alu_src_imm = 1'b1;
        imm32       = {{20{instr[31]}}, instr[31:20]};
      end
      OPC_BRANCH: begin
        rs2_used = 1'b1;
        branch   = 1'b1;
        alu_op   = {1'b0, funct3};
        imm32    = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      OPC_LOAD: begin
        rd_used     = 1'b1;
        reg_write   = 1'b1;
        mem_read    = 1'b1;
        wb_sel_mem  = 1'b1;
        alu_src_imm = 1'b1;
        imm32       = {{20{instr[31]}}, instr[31:20]};
      end
      OPC_STORE: begin
        rs2_used    = 1'b1;
        mem_write   = 1'b1;
        alu_src_imm = 1'b1;
        imm32       = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      OPC_OPIMM: begin
        rd_used     = 1'b1;
        reg_write   = 1'b1;
        alu_src_imm = 1'b1;
        alu_op      = {(funct3 == 3'b101) ? instr[30] : 1'b0, funct3};
        imm32       = {{20{instr[31]}}, instr[31:20]};
      end
      OPC_OP: begin
        rs2_used  = 1'b1;
        rd_used   = 1'b1;
        reg_write = 1'b1;
        alu_op    = {instr[30], funct3};
      end
      default: known = 1'b0;
    endcase

    illegal = !known || (rs1_used && !idx_ok(rs1)) ||
              (rs2_used && !idx_ok(rs2)) || (rd_used && !idx_ok(rd));
    // Illegal slots still flow downstream but must not cause side effects.
    if (illegal) begin
      reg_write = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      branch    = 1'b0;
      jump      = 1'b0;
    end
  end

  // Load-use stall: the loaded value is not yet available to this instruction.
  always_comb begin
    hazard = ex_mem_read && ex_rd != 5'd0 &&
             ((rs1_used && ex_rd == rs1) || (rs2_used && ex_rd == rs2));
    ready  = (!out_valid_q || bus.out_ready) && !hazard && !flush;
    accept = bus.in_valid && ready;
  end

  // Output slot: flush dominates, then accept, then drain on out_ready.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_pc_q    <= '0;
      out_ridx_q  <= '0;
      out_rs1_q   <= '0;
      out_rs2_q   <= '0;
      out_imm_q   <= '0;
      out_ctrl_q  <= '0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_pc_q    <= bus.in_pc;
      out_ridx_q  <= {rs1, rs2, rd};
      out_rs1_q   <= rs1_val;
      out_rs2_q   <= rs2_val;
      out_imm_q   <= XLEN'($signed(imm32));
      out_ctrl_q  <= {illegal, alu_op, reg_write, mem_read, mem_write,
                      branch, jump, alu_src_imm, wb_sel_mem};
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready     = ready;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_pc       = out_pc_q;
  assign bus.out_ridx     = out_ridx_q;
  assign bus.out_rs1_data = out_rs1_q;
  assign bus.out_rs2_data = out_rs2_q;
  assign bus.out_imm      = out_imm_q;
  assign bus.out_ctrl     = out_ctrl_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed self-checking bench for id_stage_pipe (NREGS=32 and NREGS=16 instances).
// Expected bypass result follows ID_WB_BYPASS_EN.
module tb_id_stage_pipe;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [4:0]  ex_rd;
  logic        ex_mem_read;

  int checks = 0;
  int errors = 0;

  id_stage_pipe_if #(.XLEN(32)) bus   ();
  id_stage_pipe_if #(.XLEN(32)) bus16 ();

  id_stage_pipe #(.XLEN(32), .NREGS(32)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .wb_we(wb_we), .wb_rd(wb_rd),
    .wb_data(wb_data), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .bus(bus.slave)
  );

  id_stage_pipe #(.XLEN(32), .NREGS(16)) dut16 (
    .clk(clk), .reset_n(reset_n), .flush(flush), .wb_we(wb_we), .wb_rd(wb_rd),
    .wb_data(wb_data), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .bus(bus16.slave)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0h expected 0", bus.out_valid); end
    checks++; if (bus.out_ctrl !== 12'h000) begin errors++; $display("FAIL reset_ctrl: got %0h expected 0", bus.out_ctrl); end
    checks++; if (bus.out_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %0h expected 0", bus.out_pc); end
    tick; tick;
    reset_n = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0h expected 1", bus.in_ready); end
  endtask

  task automatic test_addi;
    wb_we = 1'b1; wb_rd = 5'd1; wb_data = 32'h5;
    tick;
    wb_we = 1'b0;
    bus.in_valid = 1'b1; bus.in_pc = 32'h100; bus.in_instr = 32'hFFF08113;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL addi_in_ready: got %0h expected 1", bus.in_ready); end
    tick;
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL addi_valid: got %0h expected 1", bus.out_valid); end
    checks++; if (bus.out_rs1_data !== 32'h5) begin errors++; $display("FAIL addi_rs1: got %0h expected 5", bus.out_rs1_data); end
    checks++; if (bus.out_imm !== 32'hFFFFFFFF) begin errors++; $display("FAIL addi_imm: got %0h expected ffffffff", bus.out_imm); end
    checks++; if (bus.out_ctrl !== 12'h042) begin errors++; $display("FAIL addi_ctrl: got %0h expected 042", bus.out_ctrl); end
    checks++; if (bus.out_ridx !== 15'h07E2) begin errors++; $display("FAIL addi_ridx: got %0h expected 07e2", bus.out_ridx); end
    checks++; if (bus.out_pc !== 32'h100) begin errors++; $display("FAIL addi_pc: got %0h expected 100", bus.out_pc); end
    tick;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL addi_bubble: got %0h expected 0", bus.out_valid); end
  endtask

  task automatic test_sub;
    wb_we = 1'b1; wb_rd = 5'd2; wb_data = 32'h3;
    tick;
    wb_we = 1'b0;
    bus.in_valid = 1'b1; bus.in_pc = 32'h104; bus.in_instr = 32'h402081B3;
    tick;
    bus.in_valid = 1'b0;
    checks++; if (bus.out_ctrl !== 12'h440) begin errors++; $display("FAIL sub_ctrl: got %0h expected 440", bus.out_ctrl); end
    checks++; if (bus.out_ridx !== 15'h0443) begin errors++; $display("FAIL sub_ridx: got %0h expected 0443", bus.out_ridx); end
    checks++; if (bus.out_rs1_data !== 32'h5) begin errors++; $display("FAIL sub_rs1: got %0h expected 5", bus.out_rs1_data); end
    checks++; if (bus.out_rs2_data !== 32'h3) begin errors++; $display("FAIL sub_rs2: got %0h expected 3", bus.out_rs2_data); end
    checks++; if (bus.out_imm !== 32'h0) begin errors++; $display("FAIL sub_imm: got %0h expected 0", bus.out_imm); end
  endtask

  task automatic test_hazard;
    ex_mem_read = 1'b1; ex_rd = 5'd1;
    bus.in_valid = 1'b1; bus.in_pc = 32'h10C; bus.in_instr = 32'h00108233;
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL hazard_stall: got %0h expected 0", bus.in_ready); end
    tick;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL hazard_bubble: got %0h expected 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL hazard_hold: got %0h expected 0", bus.in_ready); end
    ex_mem_read = 1'b0;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL hazard_release: got %0h expected 1", bus.in_ready); end
    tick;
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL hazard_accept: got %0h expected 1", bus.out_valid); end
    checks++; if (bus.out_ridx !== 15'h0424) begin errors++; $display("FAIL hazard_ridx: got %0h expected 0424", bus.out_ridx); end
    checks++; if (bus.out_rs2_data !== 32'h5) begin errors++; $display("FAIL hazard_rs2: got %0h expected 5", bus.out_rs2_data); end
    // LUI does not read rs1, so a load writing its rs1 field must not stall it.
    ex_mem_read = 1'b1; ex_rd = 5'd8;
    bus.in_pc = 32'h110; bus.in_instr = 32'h123452B7;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL lui_no_stall: got %0h expected 1", bus.in_ready); end
    tick;
    bus.in_valid = 1'b0; ex_mem_read = 1'b0;
    checks++; if (bus.out_imm !== 32'h12345000) begin errors++; $display("FAIL lui_imm: got %0h expected 12345000", bus.out_imm); end
    checks++; if (bus.out_ctrl !== 12'h042) begin errors++; $display("FAIL lui_ctrl: got %0h expected 042", bus.out_ctrl); end
  endtask

  task automatic test_back_to_back;
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_pc = 32'h114; bus.in_instr = 32'h00208463;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready[%0d]: got %0h expected 0", i, bus.in_ready); end
      checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h110 || bus.out_imm !== 32'h12345000)
        begin errors++; $display("FAIL stall_hold[%0d]: got v=%0h pc=%0h imm=%0h expected v=1 pc=110 imm=12345000", i, bus.out_valid, bus.out_pc, bus.out_imm); end
      tick;
    end
    bus.out_ready = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL stall_release: got %0h expected 1", bus.in_ready); end
    tick;
    bus.in_valid = 1'b0;
    checks++; if (bus.out_pc !== 32'h114) begin errors++; $display("FAIL beq_pc: got %0h expected 114", bus.out_pc); end
    checks++; if (bus.out_imm !== 32'h8) begin errors++; $display("FAIL beq_imm: got %0h expected 8", bus.out_imm); end
    checks++; if (bus.out_ctrl !== 12'h008) begin errors++; $display("FAIL beq_ctrl: got %0h expected 008", bus.out_ctrl); end
  endtask

  task automatic test_flush;
    bus.in_valid = 1'b1; bus.in_pc = 32'h118; bus.in_instr = 32'h0020A223;
    flush = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %0h expected 0", bus.in_ready); end
    tick;
    flush = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_drop: got %0h expected 0", bus.out_valid); end
    tick;
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_imm !== 32'h4 || bus.out_ctrl !== 12'h012)
      begin errors++; $display("FAIL sw_decode: got v=%0h imm=%0h ctrl=%0h expected v=1 imm=4 ctrl=012", bus.out_valid, bus.out_imm, bus.out_ctrl); end
    bus.out_ready = 1'b0; flush = 1'b1;
    tick;
    flush = 1'b0; bus.out_ready = 1'b1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_stalled_slot: got %0h expected 0", bus.out_valid); end
  endtask

  task automatic test_bypass;
    logic [31:0] exp_same_edge;
`ifdef ID_WB_BYPASS_EN
    exp_same_edge = 32'hDEADBEEF;
`else
    exp_same_edge = 32'h0;
`endif
    wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEADBEEF;
    bus.in_valid = 1'b1; bus.in_pc = 32'h200; bus.in_instr = 32'h00028313;
    tick;
    wb_we = 1'b0; bus.in_valid = 1'b0;
    checks++; if (bus.out_rs1_data !== exp_same_edge) begin errors++; $display("FAIL bypass_same_edge: got %0h expected %0h", bus.out_rs1_data, exp_same_edge); end
    tick;
    bus.in_valid = 1'b1;
    tick;
    bus.in_valid = 1'b0;
    checks++; if (bus.out_rs1_data !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass_later_read: got %0h expected deadbeef", bus.out_rs1_data); end
    wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'h123;
    bus.in_valid = 1'b1; bus.in_instr = 32'h00000313;
    tick;
    wb_we = 1'b0; bus.in_valid = 1'b0;
    checks++; if (bus.out_rs1_data !== 32'h0) begin errors++; $display("FAIL x0_write_ignored: got %0h expected 0", bus.out_rs1_data); end
  endtask

  task automatic test_illegal;
    bus.in_valid = 1'b1; bus.in_instr = 32'h0000000F;
    tick;
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_ctrl !== 12'h800)
      begin errors++; $display("FAIL unknown_opcode: got v=%0h ctrl=%0h expected v=1 ctrl=800", bus.out_valid, bus.out_ctrl); end
    bus16.in_valid = 1'b1; bus16.in_pc = 32'h300; bus16.in_instr = 32'h000008B3;
    tick;
    checks++; if (bus16.out_valid !== 1'b1 || bus16.out_ctrl !== 12'h800)
      begin errors++; $display("FAIL rv32e_rd17: got v=%0h ctrl=%0h expected v=1 ctrl=800", bus16.out_valid, bus16.out_ctrl); end
    bus16.in_instr = 32'h000007B3;
    tick;
    bus16.in_valid = 1'b0;
    checks++; if (bus16.out_ctrl !== 12'h040) begin errors++; $display("FAIL rv32e_rd15: got %0h expected 040", bus16.out_ctrl); end
  endtask

  task automatic test_reset_mid;
    bus.in_valid = 1'b1; bus.in_pc = 32'h400; bus.in_instr = 32'h00028313;
    tick;
    checks++; if (bus.out_rs1_data !== 32'hDEADBEEF) begin errors++; $display("FAIL premid_rs1: got %0h expected deadbeef", bus.out_rs1_data); end
    bus.out_ready = 1'b0;
    #3;
    reset_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.out_rs1_data !== 32'h0 || bus.out_ctrl !== 12'h0)
      begin errors++; $display("FAIL mid_reset_clear: got v=%0h rs1=%0h ctrl=%0h expected all 0", bus.out_valid, bus.out_rs1_data, bus.out_ctrl); end
    tick;
    reset_n = 1'b1; bus.out_ready = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %0h expected 1", bus.in_ready); end
    tick;
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_rs1_data !== 32'h0)
      begin errors++; $display("FAIL post_reset_regs: got v=%0h rs1=%0h expected v=1 rs1=0", bus.out_valid, bus.out_rs1_data); end
  endtask

  initial begin
    reset_n = 1'b0; flush = 1'b0; wb_we = 1'b0; wb_rd = '0; wb_data = '0;
    ex_rd = '0; ex_mem_read = 1'b0;
    bus.in_valid = 1'b0; bus.in_pc = '0; bus.in_instr = '0; bus.out_ready = 1'b1;
    bus16.in_valid = 1'b0; bus16.in_pc = '0; bus16.in_instr = '0; bus16.out_ready = 1'b1;
    test_reset;
    test_addi;
    test_sub;
    test_hazard;
    test_back_to_back;
    test_flush;
    test_bypass;
    test_illegal;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_stage_pipe.md
ID_STAGE_PIPE -- requirements
Module: id_stage_pipe

Interface
REQ-001 Parameter XLEN, default 32, register and datapath width.
REQ-002 Parameter NREGS, default 32, architectural register count (16 selects RV32E).
REQ-003 clk  input  1  rising-edge clock; single clock domain.
REQ-004 reset_n  input  1  asynchronous active-low reset.
REQ-005 flush  input  1  discard the output slot and any input offered this cycle.
REQ-006 in_valid  input  1  upstream instruction valid.
REQ-007 in_ready  output  1  stage accepts the instruction this cycle.
REQ-008 in_pc  input  XLEN  PC of the offered instruction.
REQ-009 in_instr  input  32  offered instruction word.
REQ-010 wb_we  input  1  writeback enable.
REQ-011 wb_rd  input  5  writeback destination index.
REQ-012 wb_data  input  XLEN  writeback data.
REQ-013 ex_rd  input  5  destination of the instruction currently in EX.
REQ-014 ex_mem_read  input  1  instruction in EX is a load.
REQ-015 out_valid  output  1  decoded slot valid.
REQ-016 out_ready  input  1  downstream accepts the slot.
REQ-017 out_pc  output  XLEN  registered PC.
REQ-018 out_ridx  output  15  {rs1, rs2, rd}.
REQ-019 out_rs1_data  output  XLEN  rs1 operand (x0 reads 0).
REQ-020 out_rs2_data  output  XLEN  rs2 operand.
REQ-021 out_imm  output  XLEN  sign-extended immediate.
REQ-022 out_ctrl  output  12  {illegal, alu_op[3:0], reg_write, mem_read, mem_write, branch, jump, alu_src_imm, wb_sel_mem}.

Function
REQ-023 Register file: NREGS x XLEN; written at the clk edge when wb_we=1 and 0<wb_rd<NREGS; writes to x0 or to wb_rd>=NREGS are ignored.
REQ-024 Latency: 1 cycle; decode and register read of in_instr are combinational and are captured into the output slot on accept (in_valid && in_ready).
REQ-025 in_ready = (!out_valid || out_ready) && !hazard && !flush.
REQ-026 hazard = ex_mem_read && ex_rd!=0 && ((rs1 used && ex_rd==rs1) || (rs2 used && ex_rd==rs2)); rs1 is used by all opcodes except LUI/AUIPC/JAL; rs2 is used by R-type/STORE/BRANCH.
REQ-027 On out_ready=1 with no accept, out_valid clears (bubble); while out_valid && !out_ready, every out_* holds stable.
REQ-028 flush=1: out_valid=0 at the next edge; flush overrides accept and hazard.
REQ-029 Immediates: I/S/B/U/J formats, sign-extended to XLEN; R-type imm=0.
REQ-030 Control: OP-IMM/LUI/AUIPC set alu_src_imm and reg_write; LOAD sets mem_read, wb_sel_mem, reg_write, alu_src_imm; STORE sets mem_write, alu_src_imm; BRANCH sets branch; JAL/JALR set jump and reg_write (JALR also sets alu_src_imm).
REQ-031 alu_op: R-type {instr[30], funct3}; OP-IMM {funct3==101 ? instr[30] : 0, funct3}; BRANCH {0, funct3}; all other opcodes 0000.
REQ-032 illegal=1 for an unknown opcode or any used index >= NREGS; when illegal=1, reg_write, mem_read, mem_write, branch and jump are 0, and the slot is still passed downstream.

Reset
REQ-033 reset_n=0 clears all registers, out_valid and every out_* to 0 immediately; after release in_ready=1 (when flush=0 and no hazard).
REQ-034 Reset asserted mid-handshake discards the slot; no partial state survives.

Configuration
REQ-035 ID_WB_BYPASS_EN defined: a write and a read of the same register at the same edge capture wb_data; undefined: the old register value is captured and forwarding is the responsibility of EX.

Verification
REQ-036 Write x1=0x00000005, then offer 0xFFF08113 (addi x2,x1,-1) -> next edge out_valid=1, out_rs1_data=5, out_imm=0xFFFFFFFF, reg_write=1, alu_src_imm=1, alu_op=0000.
REQ-037 Offer 0x402081B3 (sub x3,x1,x2) -> alu_op=1000, alu_src_imm=0, out_ridx={1,2,3}.
REQ-038 ex_mem_read=1, ex_rd=1, offer 0x00108233 (add x4,x1,x1) -> in_ready=0 and out_valid=0 after out_ready; drop ex_mem_read -> accepted at the next edge.
REQ-039 out_ready=0 for 3 cycles with in_valid=1 -> out_* stable, in_ready=0, next instruction delivered intact afterwards; flush=1 on any cycle -> out_valid=0 at the next edge.
REQ-040 wb_we x5=0xDEADBEEF on the same edge as accepting 0x00028313 -> out_rs1_data=0xDEADBEEF with the macro defined, 0 without it; NREGS=16 with 0x000008B3 (rd=x17) -> illegal=1, reg_write=0.
